vga_timing_generator: RTL and testbench
=======================================

# vga_timing_generator

Parametrised VGA timing and pixel-output controller. It generates the raster scan, sync and blanking for any mode given by porch/sync parameters, with configurable sync polarity, colour depth and pixel-source latency. It sits between the game renderer (frame-buffer or sprite logic, which is addressed by `x`/`y`) and the board DAC pins, and generalises the fixed 640x480, 3-bit-colour controller.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch. `H_SYNC`, 96: horizontal sync width. `H_BP`, 48: horizontal back porch.
- `V_ACTIVE`, 480: visible lines. `V_FP`, 10: vertical front porch. `V_SYNC`, 2: vertical sync width. `V_BP`, 33: vertical back porch.
- `HS_POL`, 0 and `VS_POL`, 0: sync active level (0 = active-low).
- `COLOUR_BITS`, 1: bits per channel on `pixel_colour`. Legal range 1..8.
- `LATENCY`, 2: cycles from `x`/`y` to valid `pixel_colour`. Legal range 0..7.
- `CW`, 11: counter/coordinate width. It must hold H and V totals minus 1.

Ports:
- `vga_clock` in 1: pixel clock. Reset is synchronous and active-high on this single clock.
- `reset` in 1: synchronous, active-high.
- `pixel_colour` in 3*COLOUR_BITS: {R,G,B}, with R in the MSBs. Must be valid `LATENCY` cycles after the matching `x`/`y`.
- `test_mode` in 1: selects the built-in colour bars (see Configuration).
- `x`, `y` out CW: current raster position (request coordinates).
- `req_valid` out 1: `x < H_ACTIVE && y < V_ACTIVE`.
- `frame_start` out 1: one-cycle pulse when x=0 and y=0.
- `line_start` out 1: one-cycle pulse when x=0 (every line).
- `VGA_R`, `VGA_G`, `VGA_B` out 8: DAC channels.
- `VGA_HS`, `VGA_VS` out 1: syncs at the configured polarity.
- `VGA_BLANK` out 1: high while visible.
- `VGA_SYNC` out 1: constant 1.
- `VGA_CLK` out 1: equal to `vga_clock`.

## Operation

- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`. `V_TOTAL` is formed the same way.
- `x` counts 0..H_TOTAL-1 and wraps to 0. `y` increments only on the x wrap, and wraps to 0 when x and y are both at their maxima.
- `x`, `y`, `req_valid`, `frame_start` and `line_start` are decoded from the registered counters, with zero delay.
- Raw horizontal sync is active for `H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC`. Vertical sync uses the same rule on `y`.
- Raw blank equals `req_valid`.
- Raw sync and blank pass through a shift register `LATENCY+1` stages deep.
- `pixel_colour` is registered once, which aligns it with the delayed controls.
- Colour expansion, per channel: the COLOUR_BITS-wide value is repeated MSB-first and truncated to 8 bits. For example, 3'b101 becomes 8'hB6, and 1'b1 becomes 8'hFF.
- When the delayed blank is 0, RGB is forced to 0.
- State is the two counters plus the delay line. No other FSM.

## Timing

- Reset values:
  - `x`=0, `y`=0.
  - `VGA_R/G/B`=0, `VGA_BLANK`=0.
  - `VGA_HS`=~HS_POL, `VGA_VS`=~VS_POL (inactive).
  - Whole delay line cleared to inactive.
- Decoded outputs follow the counters during reset: `req_valid`=1, `frame_start`=1 and `line_start`=1 while reset is held.
- On the first clock after reset deasserts, counters advance to x=1. So x=0,y=0 is presented in the last reset cycle.
- Reset asserted mid-frame: counters return to 0 on the next edge, and the pipeline is cleared within the same cycle (no stale syncs).
- Output latency: `VGA_*` colour, sync and blank correspond to the counter value of exactly `LATENCY+1` cycles earlier.
- Wrap boundaries:
  - x = H_TOTAL-1 → 0 with y+1 in the same edge.
  - At y = V_TOTAL-1 and x = H_TOTAL-1, the next edge gives x=0,y=0 and `frame_start`=1.
- The `frame_start` period is H_TOTAL*V_TOTAL cycles. The `line_start` period is H_TOTAL cycles.

## Configuration

- Macro `VGA_TEST_PATTERN_EN`.
- Defined:
  - When `test_mode`=1, the registered colour source is replaced by 8 vertical bars.
  - Bar index = x / (H_ACTIVE/8), computed on the delayed x. `H_ACTIVE` must be a multiple of 8.
  - Index bit2 gives R, bit1 gives G, bit0 gives B. Each channel is 8'hFF or 8'h00.
  - `test_mode` changes take effect at the next pixel.
- Undefined: `test_mode` is ignored, `pixel_colour` is always used, and no bar logic is synthesised.

## Test plan

- **Small mode reset.** Params H 8/2/3/3, V 4/1/2/1. Hold `reset` 3 cycles, then release.
  - During reset: HS=1, VS=1, BLANK=0, RGB=0.
  - x sequence 1..15 then 0. `frame_start` repeats every 128 cycles.
  - Reasserting reset at x=5,y=2 gives x=0,y=0 next cycle.
- **Default 640x480.** `VGA_HS` is low for exactly 96 cycles per 800. `VGA_VS` is low for 1600 cycles per frame of 420000 cycles. `VGA_BLANK` is high for 640 cycles per line on 480 lines.
- **Latency alignment.** LATENCY=2, `pixel_colour` = {x[0],1'b0,1'b1} delayed 2 cycles.
  - First cycle of `VGA_BLANK`=1 shows R=00, G=00, B=FF.
  - Next cycle shows R=FF.
  - RGB is 0 during blanking.
- **Colour depth.** COLOUR_BITS=3, `pixel_colour`=9'b101_011_111 → R=8'hB6, G=8'h6D, B=8'hFF.
- **Polarity.** HS_POL=1, VS_POL=1. HS/VS are high only during the sync windows, and both are 0 after reset.
- **Test pattern.** With `VGA_TEST_PATTERN_EN` defined and `test_mode`=1, default mode:
  - Pixel x=0 gives RGB 00/00/00.
  - x=80 gives B=FF only.
  - x=639 gives all FF.
  - Without the macro, the same stimulus outputs `pixel_colour`.

Source files
------------

// File: rtl/vga_timing_generator_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_generator_if
//  Description : Bundle between the VGA timing generator, the pixel renderer
//                (raster request / colour return) and the board DAC pins.
//                master = timing generator, slave = renderer / board side.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_timing_generator_if #(
   parameter int COLOUR_BITS = 1,
   parameter int CW          = 11
);
   // renderer side
   logic [3*COLOUR_BITS-1:0] pixel_colour;
   logic                     test_mode;
   logic [CW-1:0]            x;
   logic [CW-1:0]            y;
   logic                     req_valid;
   logic                     frame_start;
   logic                     line_start;
   // DAC / connector side
   logic [7:0]               VGA_R;
   logic [7:0]               VGA_G;
   logic [7:0]               VGA_B;
   logic                     VGA_HS;
   logic                     VGA_VS;
   logic                     VGA_BLANK;
   logic                     VGA_SYNC;
   logic                     VGA_CLK;

   modport master (
      input  pixel_colour, test_mode,
      output x, y, req_valid, frame_start, line_start,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK
   );

   modport slave (
      output pixel_colour, test_mode,
      input  x, y, req_valid, frame_start, line_start,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_generator
//  Description : Parametrised VGA raster/sync/blank generator with a
//                LATENCY-aligned pixel colour path and per-channel colour
//                expansion to 8-bit DAC values.
//                Optional feature macro: VGA_TEST_PATTERN_EN (8 colour bars
//                selected by test_mode).
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_generator #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int COLOUR_BITS = 1,
   parameter int LATENCY     = 2,
   parameter int CW          = 11
) (
   input  wire logic               vga_clock,
   input  wire logic               reset,
   vga_timing_generator_if.master  bus
);

   localparam logic [CW-1:0] c_one      = CW'(1);
   localparam logic [CW-1:0] c_h_max    = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CW-1:0] c_v_max    = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CW-1:0] c_h_act    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] c_v_act    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] c_hs_start = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] c_hs_end   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] c_vs_start = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] c_vs_end   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam int            c_dly_w    = 3 * (LATENCY + 1);

   logic [CW-1:0]            x_q, x_d;
   logic [CW-1:0]            y_q, y_d;
   logic                     w_visible;
   logic                     w_hs_act;
   logic                     w_vs_act;
   logic [2:0]               w_ctl_raw;
   logic [c_dly_w-1:0]       ctl_q;
   logic [2:0]               w_ctl_dly;
   logic [3*COLOUR_BITS-1:0] colour_q;
   logic [2:0][7:0]          w_exp;
   logic [2:0][7:0]          w_src;

   // Raster counter next state: x wraps at the line end, y steps on that wrap
   always_comb begin
      x_d = x_q + c_one;
      y_d = y_q;
      if (x_q == c_h_max) begin
         x_d = '0;
         if (y_q == c_v_max) begin
            y_d = '0;
         end else begin
            y_d = y_q + c_one;
         end
      end
   end

   // Raster counter registers
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Zero-delay decodes of the current raster position
   assign w_visible = (x_q < c_h_act) && (y_q < c_v_act);
   assign w_hs_act  = (x_q >= c_hs_start) && (x_q < c_hs_end);
   assign w_vs_act  = (y_q >= c_vs_start) && (y_q < c_vs_end);
   // Controls are carried active-high; polarity is applied at the pins
   assign w_ctl_raw = {w_hs_act, w_vs_act, w_visible};

   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.req_valid   = w_visible;
   assign bus.frame_start = (x_q == '0) && (y_q == '0);
   assign bus.line_start  = (x_q == '0);

   // Control delay line, LATENCY+1 stages, cleared to inactive on reset
   if (LATENCY == 0) begin : g_ctl_lat0
      always_ff @(posedge vga_clock) begin
         if (reset) begin
            ctl_q <= '0;
         end else begin
            ctl_q <= w_ctl_raw;
         end
      end
   end else begin : g_ctl_latn
      always_ff @(posedge vga_clock) begin
         if (reset) begin
            ctl_q <= '0;
         end else begin
            ctl_q <= {ctl_q[3*LATENCY-1:0], w_ctl_raw};
         end
      end
   end

   assign w_ctl_dly = ctl_q[3*LATENCY +: 3];

   // Single colour register: renderer latency LATENCY plus this stage lines
   // the colour up with the LATENCY+1 deep control line
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         colour_q <= '0;
      end else begin
         colour_q <= bus.pixel_colour;
      end
   end

   // Expansion: repeat the channel value MSB-first, truncate to 8 bits
   for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      for (genvar b = 0; b < 8; b++) begin : g_bit
         assign w_exp[ch][7-b] = colour_q[ch*COLOUR_BITS + COLOUR_BITS - 1 - (b % COLOUR_BITS)];
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [CW-1:0] c_bar_w = CW'(H_ACTIVE / 8);

   logic [(LATENCY+1)*CW-1:0] xdly_q;
   logic                      test_mode_q;
   logic [CW-1:0]             w_x_dly;
   logic [2:0]                w_bar_idx;

   // Raster x delayed to match the pixel currently on the pins
   if (LATENCY == 0) begin : g_x_lat0
      always_ff @(posedge vga_clock) begin
         if (reset) begin
            xdly_q <= '0;
         end else begin
            xdly_q <= x_q;
         end
      end
   end else begin : g_x_latn
      always_ff @(posedge vga_clock) begin
         if (reset) begin
            xdly_q <= '0;
         end else begin
            xdly_q <= {xdly_q[LATENCY*CW-1:0], x_q};
         end
      end
   end

   // test_mode is sampled alongside the colour so it switches on a pixel edge
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         test_mode_q <= 1'b0;
      end else begin
         test_mode_q <= bus.test_mode;
      end
   end

   assign w_x_dly   = xdly_q[LATENCY*CW +: CW];
   assign w_bar_idx = 3'(w_x_dly / c_bar_w);

   // Bars: index bit2 -> R, bit1 -> G, bit0 -> B, full scale or off
   always_comb begin
      w_src = w_exp;
      if (test_mode_q) begin
         w_src[2] = {8{w_bar_idx[2]}};
         w_src[1] = {8{w_bar_idx[1]}};
         w_src[0] = {8{w_bar_idx[0]}};
      end
   end
`else
   logic w_unused_test_mode;

   assign w_unused_test_mode = bus.test_mode;
   assign w_src              = w_exp;
`endif

   // Pins: colour gated by delayed blank, syncs at configured polarity
   assign bus.VGA_R     = w_ctl_dly[0] ? w_src[2] : 8'h00;
   assign bus.VGA_G     = w_ctl_dly[0] ? w_src[1] : 8'h00;
   assign bus.VGA_B     = w_ctl_dly[0] ? w_src[0] : 8'h00;
   assign bus.VGA_HS    = w_ctl_dly[2] ? HS_POL : ~HS_POL;
   assign bus.VGA_VS    = w_ctl_dly[1] ? VS_POL : ~VS_POL;
   assign bus.VGA_BLANK = w_ctl_dly[0];
   assign bus.VGA_SYNC  = 1'b1;
   assign bus.VGA_CLK   = vga_clock;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_generator
//  Description : Two small-mode generators (16x8 total raster) run in lockstep.
//                A: active-low syncs, 1-bit colour, LATENCY 2, renderer
//                   returns {x[0],0,1} two cycles after each request.
//                B: active-high syncs, 3-bit colour, LATENCY 0, constant
//                   colour 101_011_111, test_mode held high.
//                Expected pin values are queued when each raster position is
//                presented and popped when that pixel reaches the pins.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_generator;

   localparam int c_la = 2;
   localparam int c_lb = 0;

   typedef logic [26:0] ent_t;   // {HS, VS, BLANK, R, G, B}

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vga_timing_generator_if #(.COLOUR_BITS(1), .CW(6)) vif_a ();
   vga_timing_generator_if #(.COLOUR_BITS(3), .CW(6)) vif_b ();

   vga_timing_generator #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOUR_BITS(1), .LATENCY(c_la), .CW(6)
   ) u_dut_a (
      .vga_clock (clk),
      .reset     (rst),
      .bus       (vif_a)
   );

   vga_timing_generator #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .COLOUR_BITS(3), .LATENCY(c_lb), .CW(6)
   ) u_dut_b (
      .vga_clock (clk),
      .reset     (rst),
      .bus       (vif_b)
   );

   ent_t qa[$];
   ent_t qb[$];
   logic xh[$];
   int   n_cmp   = 0;
   int   n_mis   = 0;
   int   mx      = 0;
   int   my      = 0;
   int   cyc     = 0;
   int   last_fs = -1;
   int   last_ls = -1;
   int   fs_cnt  = 0;

   function automatic ent_t mk(input bit hs, input bit vs, input bit bl,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return {hs, vs, bl, r, g, b};
   endfunction

   function automatic ent_t exp_a(input int x, input int y);
      bit bl = (x < 8) && (y < 4);
      bit hs = (x >= 10) && (x < 13);
      bit vs = (y >= 5) && (y < 7);
      return mk(!hs, !vs, bl, (bl && (x % 2 == 1)) ? 8'hFF : 8'h00, 8'h00, bl ? 8'hFF : 8'h00);
   endfunction

   function automatic ent_t exp_b(input int x, input int y);
      bit bl = (x < 8) && (y < 4);
      bit hs = (x >= 10) && (x < 13);
      bit vs = (y >= 5) && (y < 7);
`ifdef VGA_TEST_PATTERN_EN
      return mk(hs, vs, bl,
                (bl && ((x >> 2) % 2 == 1)) ? 8'hFF : 8'h00,
                (bl && ((x >> 1) % 2 == 1)) ? 8'hFF : 8'h00,
                (bl && (x % 2 == 1))        ? 8'hFF : 8'h00);
`else
      return mk(hs, vs, bl, bl ? 8'hB6 : 8'h00, bl ? 8'h6D : 8'h00, bl ? 8'hFF : 8'h00);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, inout ent_t q[$], input ent_t obs);
      if (q.size() == 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
      end else begin
         check(tag, 32'(obs), 32'(q.pop_front()));
      end
   endtask

   task automatic fill_inactive();
      qa.delete();
      qb.delete();
      repeat (c_la + 1) qa.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00));
      repeat (c_lb + 1) qb.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
   endtask

   // One pixel clock: check at the falling edge, drive, advance the model
   task automatic step(input logic rst_next);
      logic xd;
      check("a_x", 32'(vif_a.x), 32'(mx));
      check("a_y", 32'(vif_a.y), 32'(my));
      check("b_x", 32'(vif_b.x), 32'(mx));
      check("b_y", 32'(vif_b.y), 32'(my));
      check("a_req_valid", 32'(vif_a.req_valid), 32'((mx < 8) && (my < 4)));
      check("a_frame_start", 32'(vif_a.frame_start), 32'((mx == 0) && (my == 0)));
      check("a_line_start", 32'(vif_a.line_start), 32'(mx == 0));
      check("a_sync", 32'(vif_a.VGA_SYNC), 32'(1));
      check("b_clk", 32'(vif_b.VGA_CLK), 32'(clk));
      pop_check("a_pins", qa, {vif_a.VGA_HS, vif_a.VGA_VS, vif_a.VGA_BLANK,
                               vif_a.VGA_R, vif_a.VGA_G, vif_a.VGA_B});
      pop_check("b_pins", qb, {vif_b.VGA_HS, vif_b.VGA_VS, vif_b.VGA_BLANK,
                               vif_b.VGA_R, vif_b.VGA_G, vif_b.VGA_B});
      if (vif_a.frame_start) begin
         if (!rst && last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(128));
         if (!rst) fs_cnt++;
         last_fs = cyc;
      end
      if (vif_a.line_start) begin
         if (!rst && last_ls >= 0) check("ls_period", 32'(cyc - last_ls), 32'(16));
         last_ls = cyc;
      end

      // drive: reset for the coming edge and the renderer's delayed reply
      rst = rst_next;
      xh.push_back(vif_a.x[0]);
      xd = 1'b0;
      if (xh.size() > c_la) xd = xh.pop_front();
      vif_a.pixel_colour = {xd, 1'b0, 1'b1};
      if (rst_next) begin
         fill_inactive();
      end else begin
         qa.push_back(exp_a(mx, my));
         qb.push_back(exp_b(mx, my));
      end

      @(posedge clk);
      cyc++;
      if (rst_next) begin
         mx = 0;
         my = 0;
      end else begin
         mx++;
         if (mx == 16) begin
            mx = 0;
            my = (my == 7) ? 0 : my + 1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst                = 1'b1;
      vif_a.test_mode    = 1'b0;
      vif_a.pixel_colour = 3'b001;
      vif_b.test_mode    = 1'b1;
      vif_b.pixel_colour = 9'b101_011_111;
      @(posedge clk);
      @(negedge clk);
      fill_inactive();
      // reset held for three edges in total
      step(1'b1);
      step(1'b1);
      repeat (300) step(1'b0);

      // run to x=5,y=2 and reassert reset mid-frame
      for (int i = 0; i < 200 && !(mx == 5 && my == 2); i++) step(1'b0);
      check("pre_rst_x", 32'(vif_a.x), 32'(5));
      check("pre_rst_y", 32'(vif_a.y), 32'(2));
      step(1'b1);
      check("mid_rst_x", 32'(vif_a.x), 32'(0));
      check("mid_rst_y", 32'(vif_a.y), 32'(0));
      check("mid_rst_hs", 32'(vif_a.VGA_HS), 32'(1));
      check("mid_rst_blank", 32'(vif_a.VGA_BLANK), 32'(0));
      repeat (200) step(1'b0);

      check("fs_seen", 32'(fs_cnt >= 3), 32'(1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
